// File: rtl/psola_pkg.sv
// Shared types and helpers for the PSOLA audio stages.
// Holds bank/player state encodings and the output saturation check.
package psola_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        PLAYING
    } bank_state_t;

    typedef enum logic {
        IDLE,
        PLAY
    } player_state_t;

    typedef enum logic [1:0] {
        SAT_NONE,
        SAT_HI,
        SAT_LO
    } sat_t;

    localparam int SAT_W = 64;

    // Classifies x against the signed range of a w-bit word.
    function automatic sat_t saturate(
        input logic signed [SAT_W-1:0] x,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return SAT_HI;
        if (x < lo) return SAT_LO;
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock dual-port block RAM, port A writes, port B reads.
// HIGH_PERFORMANCE adds an output register on port B (2-cycle read).
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int    RAM_WIDTH       = 32,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic                         clka,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         wea,
    input  logic                         ena,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic                         enb,
    input  logic                         rstb,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_b;

    always_ff @(posedge clka) begin
        if (ena && wea) mem[addra] <= dina;
        if (enb) ram_b <= mem[addrb];
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_lat
            assign doutb = ram_b;
        end else begin : g_high_perf
            logic [RAM_WIDTH-1:0] doutb_r;
            always_ff @(posedge clka) begin
                if (rstb) doutb_r <= '0;
                else if (regceb) doutb_r <= ram_b;
            end
            assign doutb = doutb_r;
        end
    endgenerate

endmodule

// File: rtl/psola_output_player.sv
// Ping-pong window capture and tick-paced audio playback for PSOLA.
// Length mismatch is absorbed by zero-fill underrun and window drops.
module psola_output_player
    import psola_pkg::*;
#(
    parameter int MAX_EXTENDED = 2200,
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int OUT_SHIFT    = 0
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic signed [IN_WIDTH-1:0]      win_val,
    input  logic [$clog2(MAX_EXTENDED)-1:0] win_addr,
    input  logic                            win_valid,
    input  logic                            win_done,
    input  logic                            sample_tick,
    output logic signed [OUT_WIDTH-1:0]     audio_out,
    output logic                            audio_valid,
    output logic                            underrun,
    output logic                            overrun,
    output logic                            playing
);

    localparam int IW = $clog2(MAX_EXTENDED);
    localparam int LW = IW + 1;
    localparam int AW = $clog2(2 * MAX_EXTENDED);
    localparam logic [LW-1:0] MAXL = LW'(MAX_EXTENDED);
    localparam logic [AW-1:0] BANK_OFS = AW'(MAX_EXTENDED);
    localparam logic signed [OUT_WIDTH-1:0] O_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] O_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    bank_state_t   bank_st [2];
    logic [LW-1:0] len [2];
    logic          wr_bank;
    logic          done_q;
    logic          dropping;
    logic [LW-1:0] run_len;

    player_state_t state;
    logic          rd_bank;
    logic [LW-1:0] rd_idx;
    logic          played_any;
    logic          v1, z1, v2, z2;

    logic [LW-1:0] addr_ext;
    logic          wr_open, wr_accept, wr_reject, done_rise, wr_commit;
    logic [AW-1:0] addra, addrb;

    assign addr_ext  = {1'b0, win_addr};
    assign wr_open   = (bank_st[wr_bank] == EMPTY) || (bank_st[wr_bank] == FILLING);
    assign wr_accept = win_valid && !dropping && wr_open && (addr_ext < MAXL);
    assign wr_reject = win_valid && !dropping && !wr_open;
    assign done_rise = win_done && !done_q;
    assign wr_commit = done_rise && !dropping
                    && (bank_st[wr_bank] == FILLING) && (run_len != '0);
    assign addra     = (wr_bank ? BANK_OFS : '0) + AW'(addr_ext);

    logic          tick_ok, at_end, release_bank;
    logic          rd_go, rd_zero, rd_sel_bank;
    logic [LW-1:0] rd_sel_idx;

    assign tick_ok      = sample_tick && !v1 && !v2;
    assign at_end       = (rd_idx == len[rd_bank]);
    assign release_bank = (state == PLAY) && tick_ok && at_end;

    always_comb begin
        rd_go       = 1'b0;
        rd_zero     = 1'b0;
        rd_sel_bank = rd_bank;
        rd_sel_idx  = rd_idx;
        unique case (state)
            IDLE: if (tick_ok) begin
                if (bank_st[rd_bank] == FULL) begin
                    rd_go      = 1'b1;
                    rd_sel_idx = '0;
                end else if (played_any) begin
                    rd_zero = 1'b1;
                end
            end
            PLAY: if (tick_ok) begin
                if (!at_end) begin
                    rd_go = 1'b1;
                end else if (bank_st[~rd_bank] == FULL) begin
                    rd_go       = 1'b1;
                    rd_sel_bank = ~rd_bank;
                    rd_sel_idx  = '0;
                end else begin
                    rd_zero = 1'b1;
                end
            end
        endcase
    end

    assign addrb = (rd_sel_bank ? BANK_OFS : '0) + AW'(rd_sel_idx);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_bank  <= 1'b0;
            done_q   <= 1'b0;
            dropping <= 1'b0;
            overrun  <= 1'b0;
            run_len  <= '0;
            len[0]   <= '0;
            len[1]   <= '0;
        end else begin
            done_q <= win_done;
            if (wr_reject) begin
                dropping <= 1'b1;
                overrun  <= 1'b1;
            end
            if (wr_accept && addr_ext >= run_len) run_len <= addr_ext + LW'(1);
            if (done_rise && dropping) dropping <= 1'b0;
            if (wr_commit) begin
                len[wr_bank] <= run_len;
                run_len      <= '0;
                wr_bank      <= ~wr_bank;
            end
        end
    end

    // Write and read events always touch different banks.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            rd_bank    <= 1'b0;
            rd_idx     <= '0;
            playing    <= 1'b0;
            played_any <= 1'b0;
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
        end else begin
            if (wr_accept && bank_st[wr_bank] == EMPTY) bank_st[wr_bank] <= FILLING;
            if (wr_commit) bank_st[wr_bank] <= FULL;
            if (release_bank) begin
                bank_st[rd_bank] <= EMPTY;
                rd_bank          <= ~rd_bank;
                state            <= IDLE;
                playing          <= 1'b0;
            end
            if (rd_go) begin
                bank_st[rd_sel_bank] <= PLAYING;
                rd_bank    <= rd_sel_bank;
                rd_idx     <= rd_sel_idx + LW'(1);
                state      <= PLAY;
                playing    <= 1'b1;
                played_any <= 1'b1;
            end
        end
    end

    logic [IN_WIDTH-1:0]     ram_q;
    logic signed [SAT_W-1:0] wide;
    sat_t                    sat_kind;
    logic signed [OUT_WIDTH-1:0] sat_val;

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (IN_WIDTH),
        .RAM_DEPTH       (2 * MAX_EXTENDED),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_ram (
        .clka   (clk_in),
        .addra  (addra),
        .dina   (win_val),
        .wea    (wr_accept),
        .ena    (wr_accept),
        .addrb  (addrb),
        .enb    (rd_go),
        .rstb   (~rst_n_in),
        .regceb (v1),
        .doutb  (ram_q)
    );

    assign wide     = $signed({{(SAT_W-IN_WIDTH){ram_q[IN_WIDTH-1]}}, ram_q}) >>> OUT_SHIFT;
    assign sat_kind = saturate(wide, OUT_WIDTH);

    always_comb begin
        sat_val = wide[OUT_WIDTH-1:0];
        unique case (sat_kind)
            SAT_HI:  sat_val = O_MAX;
            SAT_LO:  sat_val = O_MIN;
            default: sat_val = wide[OUT_WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            v1          <= 1'b0;
            z1          <= 1'b0;
            v2          <= 1'b0;
            z2          <= 1'b0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            v1          <= rd_go || rd_zero;
            z1          <= rd_zero;
            v2          <= v1;
            z2          <= z1;
            audio_valid <= v2;
            if (v2) audio_out <= z2 ? '0 : sat_val;
            if (v2 && z2) underrun <= 1'b1;
        end
    end

endmodule

// File: doc/psola_output_player.md
# psola_output_player

Downstream playback stage for the PSOLA window engine. Captures each variable-length processed window (up to MAX_EXTENDED samples) into a ping-pong buffer. Streams finished windows out one sample per `sample_tick`, scaled and saturated to the audio word width. Handles window-length mismatch at the output rate by flagging underrun (zero fill) and overrun (dropped window), never by stalling the producer.

## Interface
Parameters:
- MAX_EXTENDED, 2200: max samples per processed window (depth of one bank)
- IN_WIDTH, 32: signed width of processed samples
- OUT_WIDTH, 16: signed width of audio output
- OUT_SHIFT, 0: arithmetic right shift applied before saturation

Ports:
- clk_in  input  1  system clock; the only clock
- rst_n_in  input  1  reset, synchronous, active-low
- win_val  input  IN_WIDTH  processed sample (signed)
- win_addr  input  $clog2(MAX_EXTENDED)  sample index within current window
- win_valid  input  1  win_val/win_addr valid this cycle
- win_done  input  1  level; high once window complete, low again after next window starts
- sample_tick  input  1  one-cycle audio-rate strobe
- audio_out  output  OUT_WIDTH  current audio sample (signed)
- audio_valid  output  1  one-cycle pulse when audio_out updates
- underrun  output  1  sticky: a tick found no sample to play
- overrun  output  1  sticky: a window was dropped
- playing  output  1  a bank is being played

## Operation
- Storage: one dual-port RAM of 2*MAX_EXTENDED words, bank b at offset b*MAX_EXTENDED; port A writes, port B reads; 2-cycle read latency.
- Per-bank state: EMPTY, FILLING, FULL, PLAYING; per-bank length register len[b].
- Write side:
  - First win_valid while write bank EMPTY sets it FILLING.
  - Writes at win_addr; tracks max(win_addr)+1 as running length.
  - Rising edge of win_done (registered compare) sets FILLING bank to FULL with latched length; write pointer then flips to the other bank.
  - If the target bank is not EMPTY when win_valid arrives: drop all writes until the next win_done rising edge; set overrun.
  - win_addr >= MAX_EXTENDED: write suppressed, length not updated.
  - A win_done edge with zero writes is ignored (no bank change).
- Read side FSM: IDLE, PLAY.
  - IDLE: on tick, if any bank FULL, mark it PLAYING, set rd_idx=0, go PLAY, and issue read in the same tick. Otherwise, if a window has ever been played, set underrun and emit a zero sample.
  - PLAY: on tick, issue read of rd_idx and increment. When rd_idx == len, release bank to EMPTY; if the other bank is FULL, start it at index 0 in that same tick (gapless); else go IDLE and emit zero with underrun.
  - Before the first window, ticks produce no audio_valid and no underrun.
- Output arithmetic: s = win_val >>> OUT_SHIFT; clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].

## Timing
- Reset (rst_n_in low at clk edge): audio_out=0, audio_valid=0, underrun=0, overrun=0, playing=0; all banks EMPTY; FSM IDLE; write pointer bank 0. Reset overrides all other inputs, including mid-window and mid-playback.
- Latency: tick at cycle t → audio_valid and audio_out at t+3 (2 RAM + 1 saturation register). Zero/underrun samples are aligned to the same t+3.
- sample_tick spacing ≥ 4 cycles is required; a tick arriving while a read is in flight is ignored.
- win_done edge at cycle t → bank FULL visible to the read side at t+1.
- Same-cycle write and read on different banks are always legal. The same bank is never simultaneously FILLING and PLAYING.
- playing is high from the tick that starts a bank until the tick that releases it without a successor.

## Structure
- Shared package psola_pkg: bank_state_t enum (EMPTY/FILLING/FULL/PLAYING), player_state_t (IDLE/PLAY), and a saturate function shared with other audio stages.
- Sub-module: xilinx_true_dual_port_read_first_1_clock_ram (RAM_WIDTH=IN_WIDTH, RAM_DEPTH=2*MAX_EXTENDED, HIGH_PERFORMANCE). Its active-high reset is driven by ~rst_n_in.

## Test plan
- Write window of len 5 (values 1..5), win_done high, ticks every 10 cycles → audio_out 1,2,3,4,5, each 3 cycles after tick; 6th tick → 0 with underrun=1.
- Two windows of len 4 back-to-back, second FULL before first ends → 8 contiguous samples with no zero and underrun stays 0.
- Third window arrives while bank0 PLAYING and bank1 FULL → third window dropped, overrun=1, played data unchanged.
- OUT_SHIFT=0, OUT_WIDTH=16, win_val=70000 and -70000 → audio_out 32767 and -32768.
- win_addr=MAX_EXTENDED written → no RAM write, length unaffected; win_done with no writes → no bank becomes FULL.
- rst_n_in low mid-playback for one cycle → all outputs 0, flags cleared, next tick produces no audio_valid.
